// File: rtl/memcopy_pkg.sv
// rtl/memcopy_pkg.sv - shared state encoding for the block-copy engine
package memcopy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mc_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block-copy engine owning the data-memory port (optional fill: MEMCOPY_FILL_EN)
module mem_copy_engine
    import memcopy_pkg::*;
#(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A-1:0] Length,
`ifdef MEMCOPY_FILL_EN
    input  logic         FillMode,
    input  logic [W-1:0] FillValue,
`endif
    output logic         Busy,
    output logic         Done,
    input  logic         CpuWriteEn,
    input  logic [A-1:0] CpuAddress,
    input  logic [W-1:0] CpuDataIn,
    output logic [W-1:0] CpuDataOut,
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddress,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut
);

    mc_state_t    state_q, state_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A-1:0] count_q, count_d;
    logic [W-1:0] hold_q, hold_d;
    logic         fill_q, fill_d;

    logic         fill_mode_in;
    logic [W-1:0] fill_value_in;

`ifdef MEMCOPY_FILL_EN
    assign fill_mode_in  = FillMode;
    assign fill_value_in = FillValue;
`else
    assign fill_mode_in  = 1'b0;
    assign fill_value_in = '0;
`endif

    // State register; reset aborts any copy in flight straight back to IDLE
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer, count and hold registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            hold_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            fill_q  <= fill_d;
        end
    end

    // Next state: fill mode preloads hold with the fill word and never visits READ
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        hold_d  = hold_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    src_d   = SrcAddr;
                    dst_d   = DstAddr;
                    count_d = Length;
                    fill_d  = fill_mode_in;
                    hold_d  = fill_value_in;
                    if (Length == '0) begin
                        state_d = DONE;
                    end else if (fill_mode_in) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                hold_d  = MemDataOut;
                src_d   = src_q + A'(1);
                state_d = WRITE;
            end
            WRITE: begin
                dst_d   = dst_q + A'(1);
                count_d = count_q - A'(1);
                if (count_q == A'(1)) begin
                    state_d = DONE;
                end else if (fill_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port mux: CPU owns memory when idle; no write may land during a reset cycle
    always_comb begin
        Busy       = 1'b1;
        Done       = 1'b0;
        MemWriteEn = 1'b0;
        MemAddress = '0;
        MemDataIn  = '0;
        CpuDataOut = '0;
        case (state_q)
            IDLE: begin
                Busy       = 1'b0;
                MemWriteEn = CpuWriteEn & ~Reset;
                MemAddress = CpuAddress;
                MemDataIn  = CpuDataIn;
                CpuDataOut = MemDataOut;
            end
            READ: begin
                MemAddress = src_q;
            end
            WRITE: begin
                MemAddress = dst_q;
                MemDataIn  = hold_q;
                MemWriteEn = ~Reset;
            end
            default: begin
                Done = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - self-checking bench for mem_copy_engine (fill test under MEMCOPY_FILL_EN)
module tb_mem_copy_engine;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] SrcAddr, DstAddr, Length;
    logic       Busy, Done;
    logic       CpuWriteEn;
    logic [7:0] CpuAddress, CpuDataIn, CpuDataOut;
    logic       MemWriteEn;
    logic [7:0] MemAddress, MemDataIn, MemDataOut;
`ifdef MEMCOPY_FILL_EN
    logic       FillMode;
    logic [7:0] FillValue;
`endif

    always #5 Clk = ~Clk;

    mem_copy_engine #(.W(8), .A(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Length     (Length),
`ifdef MEMCOPY_FILL_EN
        .FillMode   (FillMode),
        .FillValue  (FillValue),
`endif
        .Busy       (Busy),
        .Done       (Done),
        .CpuWriteEn (CpuWriteEn),
        .CpuAddress (CpuAddress),
        .CpuDataIn  (CpuDataIn),
        .CpuDataOut (CpuDataOut),
        .MemWriteEn (MemWriteEn),
        .MemAddress (MemAddress),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut)
    );

    // data memory with combinational read; also logs engine accesses
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] saved   [256];
    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];
    logic       rec_en = 1'b0;

    assign MemDataOut = mem[MemAddress];

    always @(posedge Clk) begin
        if (rec_en && Busy && !Done) begin
            if (MemWriteEn) wr_q.push_back(MemAddress);
            else            rd_q.push_back(MemAddress);
        end
        if (MemWriteEn) mem[MemAddress] = MemDataIn;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    // reference: ascending word-by-word copy/fill on a snapshot of memory
    task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                            input int exp_cycle, input bit fill, input logic [7:0] fv,
                            input string name);
        int done_cyc, cyc, busy_bad, cdo_bad, wr_bad, rd_bad, mem_bad;
        logic [7:0] a, b;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < int'(len); i++) begin
            a = dst + 8'(i);
            b = src + 8'(i);
            ref_mem[a] = fill ? fv : ref_mem[b];
        end
        wr_q.delete();
        rd_q.delete();
        @(negedge Clk);
        rec_en = 1'b1;
        Start = 1'b1; SrcAddr = src; DstAddr = dst; Length = len;
        CpuWriteEn = 1'b0;
`ifdef MEMCOPY_FILL_EN
        FillMode = fill; FillValue = fv;
`endif
        @(posedge Clk);
        done_cyc = -1; cyc = 0; busy_bad = 0; cdo_bad = 0;
        while (done_cyc < 0 && cyc < 700) begin
            @(negedge Clk);
            cyc++;
            if (Busy !== 1'b1) busy_bad++;
            if (CpuDataOut !== 8'h00) cdo_bad++;
            if (Done === 1'b1) begin
                done_cyc = cyc;
                Start = 1'b0;
                CpuWriteEn = 1'b0;
            end else begin
                // ignored traffic while busy
                Start      = 1'($urandom);
                SrcAddr    = 8'($urandom);
                DstAddr    = 8'($urandom);
                Length     = 8'($urandom);
                CpuWriteEn = 1'($urandom);
                CpuAddress = 8'($urandom);
                CpuDataIn  = 8'($urandom);
`ifdef MEMCOPY_FILL_EN
                FillMode   = 1'($urandom);
                FillValue  = 8'($urandom);
`endif
            end
        end
        Start = 1'b0;
        CpuWriteEn = 1'b0;
        @(negedge Clk);
        rec_en = 1'b0;
        check($sformatf("%s done_cycle", name), done_cyc, exp_cycle);
        check($sformatf("%s busy_after", name), int'(Busy), 0);
        check($sformatf("%s done_single_pulse", name), int'(Done), 0);
        check($sformatf("%s busy_during", name), busy_bad, 0);
        check($sformatf("%s cpu_dout_zero", name), cdo_bad, 0);
        check($sformatf("%s write_count", name), wr_q.size(), int'(len));
        wr_bad = 0;
        foreach (wr_q[i]) if (wr_q[i] != dst + 8'(i)) wr_bad++;
        check($sformatf("%s write_order", name), wr_bad, 0);
        check($sformatf("%s read_count", name), rd_q.size(), fill ? 0 : int'(len));
        rd_bad = 0;
        foreach (rd_q[i]) if (rd_q[i] != src + 8'(i)) rd_bad++;
        check($sformatf("%s read_order", name), rd_bad, 0);
        mem_bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mem_bad++;
        check($sformatf("%s mem_words_wrong", name), mem_bad, 0);
    endtask

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        int         exp_cycle;
        string      name;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int bad, done_seen;
        logic [7:0] s, d, l;

        tbl[0] = '{src: 8'h00, dst: 8'h80, len: 8'd4,   exp_cycle: 9,   name: "copy4"};
        tbl[1] = '{src: 8'h33, dst: 8'h44, len: 8'd0,   exp_cycle: 1,   name: "len0"};
        tbl[2] = '{src: 8'hFE, dst: 8'h40, len: 8'd3,   exp_cycle: 7,   name: "wrap"};
        tbl[3] = '{src: 8'h20, dst: 8'h21, len: 8'd4,   exp_cycle: 9,   name: "overlap"};
        tbl[4] = '{src: 8'h10, dst: 8'hF0, len: 8'd255, exp_cycle: 511, name: "maxlen"};

        randomize_mem();
        Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Length = '0;
        CpuAddress = 8'h05; CpuDataIn = ~mem[5]; CpuWriteEn = 1'b1;
`ifdef MEMCOPY_FILL_EN
        FillMode = 1'b0; FillValue = '0;
`endif
        s = mem[5];
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset busy", int'(Busy), 0);
        check("reset done", int'(Done), 0);
        check("reset memwe", int'(MemWriteEn), 0);
        check("reset no_write", int'(mem[5]), int'(s));
        Reset = 1'b0;
        CpuWriteEn = 1'b0;

        // CPU pass-through
        @(negedge Clk);
        CpuWriteEn = 1'b1; CpuAddress = 8'h10; CpuDataIn = 8'hA5;
        #1;
        check("pass memwe", int'(MemWriteEn), 1);
        check("pass addr", int'(MemAddress), 8'h10);
        check("pass wdata", int'(MemDataIn), 8'hA5);
        @(posedge Clk);
        @(negedge Clk);
        CpuWriteEn = 1'b0; CpuAddress = 8'h10;
        #1;
        check("pass mem", int'(mem[8'h10]), 8'hA5);
        check("pass cpu_dout", int'(CpuDataOut), 8'hA5);

        // directed table
        for (int i = 0; i < 5; i++) begin
            randomize_mem();
            if (i == 0) begin
                mem[0] = 8'h62; mem[1] = 8'h63; mem[2] = 8'h64; mem[3] = 8'h20;
            end
            if (i == 3) mem[8'h20] = 8'h07;
            run_copy(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].exp_cycle, 1'b0, 8'h00, tbl[i].name);
            if (i == 0) check("copy4 mem83", int'(mem[8'h83]), 8'h20);
            if (i == 3) check("overlap mem24", int'(mem[8'h24]), 8'h07);
        end

        // randomized copies against the reference
        for (int i = 0; i < 6; i++) begin
            randomize_mem();
            s = 8'($urandom);
            d = 8'($urandom);
            l = 8'($urandom_range(0, 20));
            run_copy(s, d, l, 2 * int'(l) + 1, 1'b0, 8'h00, $sformatf("rand%0d", i));
        end

        // reset in cycle 3 of a 4-word copy
        randomize_mem();
        for (int i = 0; i < 256; i++) saved[i] = mem[i];
        saved[8'h80] = mem[0];
        @(negedge Clk);
        Start = 1'b1; SrcAddr = 8'h00; DstAddr = 8'h80; Length = 8'd4;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("abort busy_before", int'(Busy), 1);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("abort busy", int'(Busy), 0);
        check("abort done", int'(Done), 0);
        Reset = 1'b0;
        done_seen = 0;
        repeat (6) begin
            @(negedge Clk);
            if (Done) done_seen++;
        end
        check("abort no_done", done_seen, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== saved[i]) bad++;
        check("abort mem_words_wrong", bad, 0);

`ifdef MEMCOPY_FILL_EN
        randomize_mem();
        run_copy(8'h00, 8'h10, 8'd5, 6, 1'b1, 8'hEE, "fill5");
        check("fill5 mem14", int'(mem[8'h14]), 8'hEE);
        randomize_mem();
        run_copy(8'h55, 8'hFD, 8'd0, 1, 1'b1, 8'h3C, "fill0");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
